baser_257b_scrambled_generator: RTL and testbench

Transmit-side 256b/257b transcoder and scrambler for the BASE-R path. It gathers four 66b blocks (64b payload plus 2b sync header) through a valid/ready handshake and packs them into one 257b transcoded block. The 256-bit payload is scrambled, and the block is presented on a registered valid/ready output. Its output is the `i_tx_scrambled` stream consumed by the 257b scrambled checker. It also keeps the same block, data and control counters as the checker, so the two ends can be compared directly.

---
 rtl/baser_pkg.sv | 15 +
 rtl/baser_257b_scrambler.sv | 41 ++++
 rtl/baser_257b_scrambled_generator.sv | 134 +++++++++++++
 tb/tb_baser_257b_scrambled_generator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/baser_pkg.sv
// Shared constants and types for the BASE-R 256b/257b transmit path.
package baser_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  // Error block: type 0x1E followed by eight 7-bit /E/ codes.
  localparam logic [63:0] EBLOCK = {{8{7'h1E}}, 8'h1E};

  localparam int SCR_TAP_A = 38;
  localparam int SCR_TAP_B = 57;

  typedef logic [256:0] block_t;

endpackage

// File: rtl/baser_257b_scrambler.sv
// Self-synchronous x^58 + x^39 + 1 scrambler, 256 payload bits per advance.
module baser_257b_scrambler
  import baser_pkg::*;
#(
  parameter logic [57:0] SCR_SEED   = 58'h3FF_FFFF_FFFF_FFFF,
  parameter bit          BYPASS_SCR = 1'b0
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_advance,
  input  logic [255:0] i_data,
  output logic [255:0] o_data
);

  logic [57:0]  state_q;
  logic [57:0]  state_d;
  logic [57:0]  walk;
  logic [255:0] scr;

  // Bit-serial walk; the state is fed back with the scrambled bits.
  always_comb begin
    walk = state_q;
    scr  = '0;
    for (int b = 0; b < 256; b++) begin
      scr[b] = i_data[b] ^ walk[SCR_TAP_A] ^ walk[SCR_TAP_B];
      walk   = {walk[56:0], scr[b]};
    end
    state_d = walk;
  end

  assign o_data = BYPASS_SCR ? i_data : scr;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= SCR_SEED;
    end else if (i_advance && !BYPASS_SCR) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/baser_257b_scrambled_generator.sv
// Gathers four 66b blocks, transcodes them into one scrambled 257b block and
// presents it on a registered valid/ready output with block/data/ctrl counters.
module baser_257b_scrambled_generator
  import baser_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter int          TC_WIDTH   = 257,
  parameter logic [57:0] SCR_SEED   = 58'h3FF_FFFF_FFFF_FFFF,
  parameter bit          BYPASS_SCR = 1'b0
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_sh,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [TC_WIDTH-1:0]   o_tx_scrambled,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sh_err,
  output logic [31:0]           o_block_count,
  output logic [31:0]           o_data_count,
  output logic [31:0]           o_ctrl_count
);

  logic [1:0]            idx_q;
  logic [DATA_WIDTH-1:0] slot_q [3];
  logic [2:0]            flag_q;
  block_t                tx_q;
  logic                  valid_q;
  logic                  sh_err_q;
  logic [31:0]           block_count_q;
  logic [31:0]           data_count_q;
  logic [31:0]           ctrl_count_q;

  logic                  word_ok;
  logic                  flag_in;
  logic [DATA_WIDTH-1:0] word_in;
  logic [DATA_WIDTH-1:0] word [4];
  logic [3:0]            flags;
  logic                  all_data;
  logic                  accept;
  logic                  build;
  logic [255:0]          payload_raw;
  logic [255:0]          payload_scr;

  assign word_ok  = (i_sh == SH_DATA) || (i_sh == SH_CTRL);
  assign flag_in  = (i_sh == SH_DATA);
  assign word_in  = word_ok ? i_data : EBLOCK;
  assign o_ready  = (idx_q != 2'd3) || !valid_q || i_ready;
  assign accept   = i_valid && o_ready;
  assign build    = accept && (idx_q == 2'd3);
  assign flags    = {flag_in, flag_q};
  assign all_data = &flags;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_slot
      assign word[gi] = slot_q[gi];
      always_ff @(posedge clk) begin
        if (i_rst) begin
          slot_q[gi] <= '0;
          flag_q[gi] <= 1'b0;
        end else if (accept && (idx_q == gi)) begin
          slot_q[gi] <= word_in;
          flag_q[gi] <= flag_in;
        end
      end
    end
  endgenerate
  assign word[3] = word_in;

  // The lowest-indexed control word is squeezed to 60 bits (type nibble + data[63:8]).
  always_comb begin
    payload_raw = {word[3], word[2], word[1], word[0]};
    if (!flags[0]) begin
      payload_raw = {word[3], word[2], word[1], word[0][63:8], word[0][3:0], flags};
    end else if (!flags[1]) begin
      payload_raw = {word[3], word[2], word[1][63:8], word[1][3:0], word[0], flags};
    end else if (!flags[2]) begin
      payload_raw = {word[3], word[2][63:8], word[2][3:0], word[1], word[0], flags};
    end else if (!flags[3]) begin
      payload_raw = {word[3][63:8], word[3][3:0], word[2], word[1], word[0], flags};
    end
  end

  baser_257b_scrambler #(
    .SCR_SEED   (SCR_SEED),
    .BYPASS_SCR (BYPASS_SCR)
  ) u_scrambler (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_advance (build),
    .i_data    (payload_raw),
    .o_data    (payload_scr)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      idx_q         <= 2'd0;
      tx_q          <= '0;
      valid_q       <= 1'b0;
      sh_err_q      <= 1'b0;
      block_count_q <= '0;
      data_count_q  <= '0;
      ctrl_count_q  <= '0;
    end else begin
      sh_err_q <= accept && !word_ok;
      if (accept) begin
        idx_q <= idx_q + 2'd1;
      end
      if (build) begin
        tx_q          <= {payload_scr, all_data};
        valid_q       <= 1'b1;
        block_count_q <= block_count_q + 32'd1;
        if (all_data) begin
          data_count_q <= data_count_q + 32'd1;
        end else begin
          ctrl_count_q <= ctrl_count_q + 32'd1;
        end
      end else if (i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_tx_scrambled = tx_q;
  assign o_valid        = valid_q;
  assign o_sh_err       = sh_err_q;
  assign o_block_count  = block_count_q;
  assign o_data_count   = data_count_q;
  assign o_ctrl_count   = ctrl_count_q;

endmodule

// File: tb/tb_baser_257b_scrambled_generator.sv
// Randomized bench: three generator configurations against a bit-queue transcoding model.
module tb_baser_257b_scrambled_generator;

  localparam logic [57:0] SEED_DEF = 58'h3FF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic [63:0] i_data = '0;
  logic [1:0]  i_sh = 2'b01;

  logic         ready_a, ready_b, ready_c;
  logic [256:0] tx_a, tx_b, tx_c;
  logic         valid_a, valid_b, valid_c;
  logic         sherr_a, sherr_b, sherr_c;
  logic [31:0]  blk_a, dat_a, ctl_a, blk_b, dat_b, ctl_b, blk_c, dat_c, ctl_c;

  always #5 clk = ~clk;

  // a: default scrambler, b: bypass, c: zero seed
  baser_257b_scrambled_generator dut_a (
    .clk(clk), .i_rst(i_rst), .i_data(i_data), .i_sh(i_sh), .i_valid(i_valid),
    .o_ready(ready_a), .o_tx_scrambled(tx_a), .o_valid(valid_a), .i_ready(i_ready),
    .o_sh_err(sherr_a), .o_block_count(blk_a), .o_data_count(dat_a), .o_ctrl_count(ctl_a));

  baser_257b_scrambled_generator #(.BYPASS_SCR(1'b1)) dut_b (
    .clk(clk), .i_rst(i_rst), .i_data(i_data), .i_sh(i_sh), .i_valid(i_valid),
    .o_ready(ready_b), .o_tx_scrambled(tx_b), .o_valid(valid_b), .i_ready(i_ready),
    .o_sh_err(sherr_b), .o_block_count(blk_b), .o_data_count(dat_b), .o_ctrl_count(ctl_b));

  baser_257b_scrambled_generator #(.SCR_SEED(58'h0)) dut_c (
    .clk(clk), .i_rst(i_rst), .i_data(i_data), .i_sh(i_sh), .i_valid(i_valid),
    .o_ready(ready_c), .o_tx_scrambled(tx_c), .o_valid(valid_c), .i_ready(i_ready),
    .o_sh_err(sherr_c), .o_block_count(blk_c), .o_data_count(dat_c), .o_ctrl_count(ctl_c));

  typedef struct {
    logic [256:0] a;
    logic [256:0] b;
    logic [256:0] c;
    logic [255:0] pay;
    int unsigned  blk;
    int unsigned  dat;
    int unsigned  ctl;
  } exp_t;

  exp_t        exp_q[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          m_idx;
  logic [63:0] m_w [4];
  bit          m_f [4];
  int unsigned m_blk, m_dat, m_ctl;
  logic [57:0] m_sa, m_sc, d_st;
  logic [63:0] ebl;
  exp_t        mon_e;
  logic [255:0] mon_rec;
  logic        mon_r;

  task automatic check(input string tag, input logic [256:0] got, input logic [256:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic scramble(input logic [255:0] p, input logic [57:0] st_in,
                          output logic [255:0] o, output logic [57:0] st_out);
    logic [57:0] st;
    logic        s;
    st = st_in;
    o  = '0;
    for (int i = 0; i < 256; i++) begin
      s    = p[i] ^ st[38] ^ st[57];
      o[i] = s;
      st   = {st[56:0], s};
    end
    st_out = st;
  endtask

  task automatic model_reset();
    m_idx = 0;
    m_blk = 0; m_dat = 0; m_ctl = 0;
    m_sa = SEED_DEF; m_sc = 58'h0; d_st = SEED_DEF;
    exp_q.delete();
  endtask

  task automatic model_build();
    bit           q[$];
    bit           hdr, seen;
    logic [255:0] p, pa, pc;
    logic [57:0]  ns;
    exp_t         e;
    hdr  = m_f[0] && m_f[1] && m_f[2] && m_f[3];
    seen = 1'b0;
    if (!hdr) for (int k = 0; k < 4; k++) q.push_back(m_f[k]);
    for (int k = 0; k < 4; k++) begin
      if (!hdr && !m_f[k] && !seen) begin
        seen = 1'b1;
        for (int b = 0; b < 4; b++) q.push_back(m_w[k][b]);
        for (int b = 8; b < 64; b++) q.push_back(m_w[k][b]);
      end else begin
        for (int b = 0; b < 64; b++) q.push_back(m_w[k][b]);
      end
    end
    p = '0;
    for (int i = 0; i < 256 && i < q.size(); i++) p[i] = q[i];
    scramble(p, m_sa, pa, ns); m_sa = ns;
    scramble(p, m_sc, pc, ns); m_sc = ns;
    m_blk++;
    if (hdr) m_dat++; else m_ctl++;
    e.a = {pa, hdr}; e.b = {p, hdr}; e.c = {pc, hdr}; e.pay = p;
    e.blk = m_blk; e.dat = m_dat; e.ctl = m_ctl;
    exp_q.push_back(e);
  endtask

  task automatic model_accept(input logic [63:0] d, input logic [1:0] sh, output bit built);
    m_w[m_idx] = (sh == 2'b01 || sh == 2'b10) ? d : ebl;
    m_f[m_idx] = (sh == 2'b01);
    built = (m_idx == 3);
    if (built) model_build();
    m_idx = (m_idx + 1) % 4;
  endtask

  task automatic send_word(input logic [63:0] d, input logic [1:0] sh);
    int budget;
    bit built;
    budget = 0;
    i_data = d; i_sh = sh; i_valid = 1'b1;
    @(negedge clk);
    while (!ready_a && budget < 20) begin
      budget++;
      @(negedge clk);
    end
    if (!ready_a) begin
      check("ready_timeout", ready_a, 1);
      i_valid = 1'b0;
      return;
    end
    check("ready_bc", {ready_b, ready_c}, 2'b11);
    model_accept(d, sh, built);
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("sh_err", {sherr_a, sherr_b, sherr_c}, {3{(sh == 2'b00 || sh == 2'b11)}});
    if (built) check("lat_valid", valid_a, 1);
  endtask

  task automatic check_reset_state();
    check("rst_valid", {valid_a, valid_b, valid_c}, 0);
    check("rst_tx", tx_a | tx_b | tx_c, 0);
    check("rst_sh_err", {sherr_a, sherr_b, sherr_c}, 0);
    check("rst_counts", {blk_a, dat_a, ctl_a}, 0);
    check("rst_ready", ready_a, 1);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] rand_sh();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 2'b01;
    if (r < 9) return 2'b10;
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  always @(negedge clk) begin
    if (!i_rst && valid_a && i_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_block", valid_a, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("blk_a", tx_a, mon_e.a);
        check("blk_b", tx_b, mon_e.b);
        check("blk_c", tx_c, mon_e.c);
        check("valid_bc", {valid_b, valid_c}, 2'b11);
        check("counts_a", {blk_a, dat_a, ctl_a}, {mon_e.blk[31:0], mon_e.dat[31:0], mon_e.ctl[31:0]});
        check("counts_bc", {blk_b, ctl_b, blk_c, ctl_c},
              {mon_e.blk[31:0], mon_e.ctl[31:0], mon_e.blk[31:0], mon_e.ctl[31:0]});
        check("data_bc", {dat_b, dat_c}, {mon_e.dat[31:0], mon_e.dat[31:0]});
        for (int i = 0; i < 256; i++) begin
          mon_r      = tx_a[i+1];
          mon_rec[i] = mon_r ^ d_st[38] ^ d_st[57];
          d_st       = {d_st[56:0], mon_r};
        end
        check("descramble", mon_rec, mon_e.pay);
      end
    end
  end

  initial begin
    ebl[7:0] = 8'h1E;
    for (int i = 0; i < 8; i++) ebl[8 + 7*i +: 7] = 7'h1E;
    model_reset();
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    check_reset_state();

    // zero data, zero seed: scrambled output is just the data header
    for (int k = 0; k < 4; k++) send_word(64'h0, 2'b01);
    check("zero_seed", tx_c, 257'h1);

    for (int k = 1; k <= 4; k++) send_word(64'(k), 2'b01);
    check("all_data_b", tx_b, {64'h4, 64'h3, 64'h2, 64'h1, 1'b1});

    send_word({$urandom, $urandom}, 2'b01);
    send_word({$urandom, 24'($urandom), 8'h1E}, 2'b10);
    send_word({$urandom, $urandom}, 2'b10);
    send_word({$urandom, $urandom}, 2'b01);
    check("mixed_hdr", tx_b[4:0], 5'b10010);
    check("mixed_type", tx_b[72:69], 4'hE);

    send_word({$urandom, $urandom}, 2'b01);
    send_word({$urandom, $urandom}, 2'b01);
    send_word({$urandom, $urandom}, 2'b11);
    send_word({$urandom, $urandom}, 2'b01);
    check("inv_hdr", tx_b[4:0], 5'b10110);
    check("inv_eblock", tx_b[192:133], {ebl[63:8], ebl[3:0]});

    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 4; k++) send_word({$urandom, $urandom}, rand_sh());
    idle(3);

    // backpressure: hold a block, gather three more, word 3 must stall
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word({$urandom, $urandom}, 2'b01);
    for (int k = 0; k < 3; k++) send_word({$urandom, $urandom}, rand_sh());
    i_data = {$urandom, $urandom}; i_sh = 2'b10; i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready", ready_a, 0);
      check("bp_hold", tx_a, (exp_q.size() > 0) ? exp_q[0].a : 257'h0);
    end
    @(posedge clk); #1 i_ready = 1'b1;
    @(negedge clk);
    check("bp_release", ready_a, 1);
    begin
      bit built;
      model_accept(i_data, i_sh, built);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("bp_new_valid", valid_a, 1);
    idle(3);

    // reset with a pending block and a partial gather
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word({$urandom, $urandom}, 2'b10);
    for (int k = 0; k < 2; k++) send_word({$urandom, $urandom}, 2'b01);
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    model_reset();
    check_reset_state();
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) send_word({$urandom, $urandom}, 2'b01);
    check("rst_gather_counts", {blk_a, dat_a, ctl_a}, {32'd1, 32'd1, 32'd0});
    idle(4);
    check("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
